// File: rtl/present_arbiter.sv
// Two-requester round-robin front end for a single PRESENT-80 block cipher core.
// Handles grant, operand capture, core start, result/timeout collection and per-requester done.
`timescale 1ns/1ps

module present_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CK,
    input  logic        RN,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] ptext0,
    input  logic [63:0] ptext1,
    input  logic [79:0] key0,
    input  logic [79:0] key1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic [63:0] ctext,
    output logic        err,
    output logic        core_start,
    output logic [63:0] core_ptext,
    output logic [79:0] core_key,
    input  logic        core_ready,
    input  logic [63:0] core_ctext
);

    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_ISSUE = 5'b00010;
    localparam logic [4:0] S_SKIP  = 5'b00100;
    localparam logic [4:0] S_WAIT  = 5'b01000;
    localparam logic [4:0] S_DONE  = 5'b10000;

    // The WAIT cycle in which the counter holds this value is the last one allowed.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [4:0]  r_state;
    logic [4:0]  w_state_nxt;
    logic        r_ptr;
    logic        r_gid;
    logic [7:0]  r_cnt;
    logic [63:0] r_ctext;
    logic        r_err;
    logic [63:0] r_core_ptext;
    logic [79:0] r_core_key;

    logic        w_grant;
    logic        w_win;
    logic        w_tmo;

    always_comb begin
        w_grant = (r_state == S_IDLE) && core_ready && (req0 || req1);
        // Pointer names the last winner, so on contention the other side goes next.
        if (req0 && req1) begin
            w_win = ~r_ptr;
        end else begin
            w_win = req1;
        end
        w_tmo = !core_ready && (r_cnt == CNT_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_SKIP;
            S_SKIP:  w_state_nxt = S_WAIT;
            S_WAIT:  if (core_ready || w_tmo) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CK) begin
        if (RN) begin
            r_state      <= S_IDLE;
            r_ptr        <= 1'b1;
            r_gid        <= 1'b0;
            r_cnt        <= 8'd0;
            r_ctext      <= 64'd0;
            r_err        <= 1'b0;
            r_core_ptext <= 64'd0;
            r_core_key   <= 80'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gid        <= w_win;
                        r_core_ptext <= w_win ? ptext1 : ptext0;
                        r_core_key   <= w_win ? key1 : key0;
                    end
                end
                S_SKIP: begin
                    r_cnt <= 8'd0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (core_ready) begin
                        r_ctext <= core_ctext;
                        r_err   <= 1'b0;
                    end else if (w_tmo) begin
                        r_ctext <= 64'd0;
                        r_err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_ptr   <= r_gid;
                    r_ctext <= 64'd0;
                    r_err   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake pulses decode straight from the registered state and grant id.
    assign ack0       = (r_state == S_ISSUE) && !r_gid;
    assign ack1       = (r_state == S_ISSUE) &&  r_gid;
    assign done0      = (r_state == S_DONE)  && !r_gid;
    assign done1      = (r_state == S_DONE)  &&  r_gid;
    assign core_start = (r_state == S_ISSUE);
    assign ctext      = r_ctext;
    assign err        = r_err;
    assign core_ptext = r_core_ptext;
    assign core_key   = r_core_key;

`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge CK) disable iff (RN) $onehot(r_state));
    a_ack_excl: assert property (@(posedge CK) !(ack0 && ack1));
    a_done_excl: assert property (@(posedge CK) !(done0 && done1));
`endif

endmodule

// File: tb/tb_present_arbiter.sv
// Scoreboard bench for present_arbiter with a behavioural PRESENT-80 core model.
`timescale 1ns/1ps

module tb_present_arbiter;

    localparam int TMO      = 16;
    localparam int CORE_LAT = 3;

    localparam logic [63:0] CT_00 = 64'h5579c1387b228445;
    localparam logic [63:0] CT_0F = 64'he72c46c0f5945049;
    localparam logic [63:0] CT_F0 = 64'ha112ffc72f68417b;
    localparam logic [63:0] CT_FF = 64'h3333dcd3213210d2;
    localparam logic [63:0] P_ONES = 64'hffff_ffff_ffff_ffff;
    localparam logic [79:0] K_ONES = 80'hffff_ffff_ffff_ffff_ffff;

    logic        CK = 1'b0;
    logic        RN = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [63:0] ptext0 = '0, ptext1 = '0;
    logic [79:0] key0 = '0, key1 = '0;
    logic        ack0, ack1, done0, done1, err, core_start;
    logic [63:0] ctext, core_ptext;
    logic [79:0] core_key;
    logic        core_ready = 1'b1;
    logic [63:0] core_ctext = '0;

    present_arbiter #(.TIMEOUT(TMO)) dut (
        .CK(CK), .RN(RN), .req0(req0), .req1(req1),
        .ptext0(ptext0), .ptext1(ptext1), .key0(key0), .key1(key1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .ctext(ctext), .err(err), .core_start(core_start),
        .core_ptext(core_ptext), .core_key(core_key),
        .core_ready(core_ready), .core_ctext(core_ctext)
    );

    always #5 CK = ~CK;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    typedef struct packed {
        logic        id;
        logic [63:0] ct;
        logic        er;
    } exp_t;

    exp_t exp_q[$];
    logic gnt_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic push_exp(input logic id, input logic [63:0] ct, input logic er);
        exp_t e;
        e.id = id;
        e.ct = ct;
        e.er = er;
        exp_q.push_back(e);
    endtask

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present80(input logic [63:0] pt, input logic [79:0] key);
        logic [63:0] s, t;
        logic [79:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int i = 0; i < 16; i++) t[4*i +: 4] = sbox(s[4*i +: 4]);
            for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (i * 16) % 63] = t[i];
            k = {k[18:0], k[79:19]};
            k[79:76] = sbox(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    // Behavioural core: drops ready after start, returns result CORE_LAT cycles later unless hung.
    logic        core_hang = 1'b0;
    logic        core_busy = 1'b0;
    int          core_cnt  = 0;
    logic [63:0] core_res  = '0;

    always @(negedge CK) begin
        if (RN) begin
            core_ready = 1'b1;
            core_busy  = 1'b0;
            core_cnt   = 0;
            core_ctext = '0;
        end else if (core_start) begin
            core_busy  = 1'b1;
            core_cnt   = CORE_LAT;
            core_ready = 1'b0;
            core_res   = present80(core_ptext, core_key);
        end else if (core_busy && !core_hang) begin
            core_cnt--;
            if (core_cnt <= 0) begin
                core_ready = 1'b1;
                core_ctext = core_res;
                core_busy  = 1'b0;
            end
        end
    end

    // Monitor: pops expected grants and results whenever the DUT presents them.
    always @(negedge CK) begin
        logic g;
        exp_t e;
        if (core_start) starts++;
        if (ack0 || ack1) begin
            chk("ack_exclusive", 128'(ack0 && ack1), 128'(0));
            chk("start_with_ack", 128'(core_start), 128'(1));
            if (gnt_q.size() == 0) begin
                chk("ack_unexpected", 128'({ack1, ack0}), 128'(0));
            end else begin
                g = gnt_q.pop_front();
                chk("grant_id", 128'(ack1), 128'(g));
            end
        end else if (core_start) begin
            chk("start_without_ack", 128'(core_start), 128'(0));
        end
        if (done0 || done1) begin
            chk("done_exclusive", 128'(done0 && done1), 128'(0));
            if (exp_q.size() == 0) begin
                chk("done_unexpected", 128'({done1, done0}), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chk("done_id", 128'(done1), 128'(e.id));
                chk("done_ctext", 128'(ctext), 128'(e.ct));
                chk("done_err", 128'(err), 128'(e.er));
            end
        end
    end

    task automatic op(input logic id, input logic [63:0] pt, input logic [79:0] k, output int lat);
        int n;
        n = 0;
        lat = -1;
        if (id) begin ptext1 = pt; key1 = k; req1 = 1'b1; end
        else    begin ptext0 = pt; key0 = k; req0 = 1'b1; end
        while (n < 200) begin
            @(negedge CK);
            n++;
            if ((id ? ack1 : ack0) === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (id) req1 = 1'b0;
        else    req0 = 1'b0;
        if (lat < 0) chk("ack_wait", 128'(0), 128'(1));
    endtask

    task automatic wait_done(input logic id, input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(negedge CK);
            n++;
            if ((id ? done1 : done0) === 1'b1) break;
        end
    endtask

    task automatic wait_empty(input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge CK);
            n++;
        end
        chk("drain", 128'(exp_q.size()), 128'(0));
    endtask

    int lat, n, l0, l1, s0;

    initial begin
        repeat (3) @(negedge CK);
        chk("reset_handshake", 128'({ack1, ack0, done1, done0, core_start}), 128'(0));
        chk("reset_result", 128'({err, ctext}), 128'(0));
        chk("reset_ptext", 128'(core_ptext), 128'(0));
        chk("reset_key", 128'(core_key), 128'(0));
        RN = 1'b0;
        @(negedge CK);

        // Single requester 0, all-zero operands.
        gnt_q.push_back(1'b0);
        push_exp(1'b0, CT_00, 1'b0);
        op(1'b0, 64'd0, 80'd0, lat);
        chk("ack_latency", 128'(lat), 128'(1));
        wait_done(1'b0, 50, n);
        chk("done_latency", 128'(n), 128'(CORE_LAT + 1));
        @(negedge CK);
        chk("result_cleared", 128'({err, ctext}), 128'(0));
        chk("done_one_cycle", 128'(done0), 128'(0));

        // Single requester 1, all-ones operands.
        gnt_q.push_back(1'b1);
        push_exp(1'b1, CT_FF, 1'b0);
        op(1'b1, P_ONES, K_ONES, lat);
        wait_empty(50);

        // Simultaneous requests right after reset: requester 0 first.
        RN = 1'b1;
        repeat (2) @(negedge CK);
        RN = 1'b0;
        @(negedge CK);
        gnt_q.push_back(1'b0);
        gnt_q.push_back(1'b1);
        push_exp(1'b0, CT_F0, 1'b0);
        push_exp(1'b1, CT_0F, 1'b0);
        fork
            op(1'b0, P_ONES, 80'd0, l0);
            op(1'b1, 64'd0, K_ONES, l1);
        join
        wait_empty(100);

        // Both held continuously for four operations.
        s0 = starts;
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
        push_exp(1'b0, CT_00, 1'b0);
        push_exp(1'b1, CT_FF, 1'b0);
        push_exp(1'b0, CT_F0, 1'b0);
        push_exp(1'b1, CT_0F, 1'b0);
        fork
            begin
                op(1'b0, 64'd0, 80'd0, l0);
                op(1'b0, P_ONES, 80'd0, l0);
            end
            begin
                op(1'b1, P_ONES, K_ONES, l1);
                op(1'b1, 64'd0, K_ONES, l1);
            end
        join
        wait_empty(200);
        chk("start_count", 128'(starts - s0), 128'(4));

        // Hung core: timeout error after TMO wait cycles, then normal service.
        core_hang = 1'b1;
        gnt_q.push_back(1'b0);
        push_exp(1'b0, 64'd0, 1'b1);
        op(1'b0, 64'h0123_4567_89ab_cdef, 80'h5678, lat);
        wait_done(1'b0, 300, n);
        chk("timeout_latency", 128'(n), 128'(TMO + 2));
        core_hang = 1'b0;
        gnt_q.push_back(1'b1);
        push_exp(1'b1, CT_FF, 1'b0);
        op(1'b1, P_ONES, K_ONES, lat);
        wait_empty(100);

        // Reset while waiting on a hung core: operation silently dropped.
        core_hang = 1'b1;
        gnt_q.push_back(1'b0);
        op(1'b0, 64'd0, 80'd0, lat);
        repeat (4) @(negedge CK);
        RN = 1'b1;
        @(negedge CK);
        chk("midop_reset_ctrl", 128'({ack1, ack0, done1, done0, core_start, err}), 128'(0));
        chk("midop_reset_ctext", 128'(ctext), 128'(0));
        chk("midop_reset_operands", 128'({core_ptext, core_key}), 128'(0));
        core_hang = 1'b0;
        repeat (2) @(negedge CK);
        RN = 1'b0;
        @(negedge CK);
        gnt_q.push_back(1'b1);
        push_exp(1'b1, CT_FF, 1'b0);
        op(1'b1, P_ONES, K_ONES, lat);
        chk("post_reset_ack_latency", 128'(lat), 128'(1));
        wait_empty(100);
        repeat (3) @(negedge CK);
        chk("grants_consumed", 128'(gnt_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/present_arbiter.md
PRESENT_ARBITER -- requirements
Module: present_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum WAIT cycles before an operation is aborted; legal range 4..255.
REQ-002 CK  input  1  clock; all state changes on rising edge.
REQ-003 RN  input  1  reset; synchronous, active-high.
REQ-004 req0, req1  input  1 each  requester operation request; level, held until matching ack.
REQ-005 ptext0, ptext1  input  64 each  requester plaintext; stable while req high.
REQ-006 key0, key1  input  80 each  requester key; stable while req high.
REQ-007 ack0, ack1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-008 done0, done1  output  1 each  one-cycle pulse: result for that requester valid on ctext/err.
REQ-009 ctext  output  64  registered result, valid only while a done pulse is high.
REQ-010 err  output  1  high with done when the operation timed out.
REQ-011 core_start  output  1  one-cycle start pulse to the PRESENT core.
REQ-012 core_ptext, core_key  output  64 / 80  registered operands to core, held from ISSUE until next grant.
REQ-013 core_ready  input  1  core idle/result valid; low from cycle after start until result valid.
REQ-014 core_ctext  input  64  core result, valid while core_ready high.

Function
REQ-015 FSM states IDLE, ISSUE, SKIP, WAIT, DONE; exactly one active.
REQ-016 IDLE: grant only when core_ready=1 and at least one req high; otherwise stay.
REQ-017 Arbitration round-robin: pointer names last granted requester; with both req high, the other one wins; single req wins unconditionally.
REQ-018 Grant in IDLE cycle T: capture operands into core_ptext/core_key, record grant id, pulse ack of winner in T+1, go ISSUE.
REQ-019 ISSUE (T+1): core_start=1 for exactly this cycle; go SKIP.
REQ-020 SKIP (T+2): core_ready ignored; clear timeout counter; go WAIT.
REQ-021 WAIT: counter increments each cycle; core_ready=1 -> capture core_ctext into ctext, err=0, go DONE.
REQ-022 WAIT: counter reaching TIMEOUT with core_ready=0 -> ctext=0, err=1, go DONE.
REQ-023 DONE: pulse done of granted requester for one cycle, update pointer, go IDLE; ctext/err cleared next cycle.
REQ-024 Minimum turnaround: ack at T+1, done at W+1 where W is cycle core_ready sampled high; next grant no earlier than W+2.
REQ-025 A requester's req re-asserted during its own operation is not accepted until IDLE; no request is lost or duplicated.
REQ-026 req dropped before ack: not granted; no ack, no done.
REQ-027 ack and done never high for both requesters in the same cycle; core_start never high outside ISSUE.

Reset
REQ-028 RN=1 at a rising edge: state IDLE, pointer=1 (requester 0 favoured first), counter 0, all outputs 0 including core operands; takes precedence over every other event.
REQ-029 Reset mid-operation discards the operation silently (no done); post-reset grants wait for core_ready=1 per REQ-016.

Verification
REQ-030 req0, ptext0=0, key0=0, real core -> ack0 one cycle after req, one core_start, done0 with ctext=64'h5579c1387b228445, err=0.
REQ-031 req1, ptext1=all ones, key1=all ones -> done1 with ctext=64'h3333dcd3213210d2, err=0.
REQ-032 req0 and req1 asserted same cycle after reset -> requester 0 served first, requester 1 next; both results correct, done pulses in separate cycles.
REQ-033 Both held continuously for 4 operations -> grant order 0,1,0,1; exactly 4 core_start pulses.
REQ-034 Stub core holds core_ready=0 after start -> done pulse with err=1, ctext=0 after TIMEOUT WAIT cycles; FSM returns IDLE.
REQ-035 RN=1 during WAIT -> no done pulse, all outputs 0 next cycle; fresh req served normally afterwards.
